// File: rtl/niosduino_pio_pkg.sv
// niosduino_pio_pkg
// Shared definitions for the NIOSDuino PIO register port and its arbiters.
//   ADDR_W           : width of the PIO register address
//   ADDR_DATA/DIR/SET/CLR : PIO register map (data_out, data_dir, bit-set, bit-clear)
//   arbState_t       : arbiter FSM states (IDLE, ISSUE, RESP)
//   oneHotToIdx()    : index of the set bit in a one-hot vector of up to 8 bits
package niosduino_pio_pkg;

  localparam int ADDR_W  = 3;
  localparam int MAX_REQ = 8;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_SET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CLR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arbState_t;

  function automatic logic [2:0] oneHotToIdx(input logic [MAX_REQ-1:0] v);
    oneHotToIdx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) begin
        oneHotToIdx = 3'(i);
      end
    end
  endfunction

endpackage

// File: rtl/niosduino_rr_pick.sv
// niosduino_rr_pick
// Combinational round-robin priority picker. The search starts one position
// after the pointer (the previous winner) and wraps modulo N; the first set
// request bit wins.
//   i_req   [N-1:0]     : request vector
//   i_ptr   [PTR_W-1:0] : index of the previous winner
//   o_grant [N-1:0]     : one-hot grant, all zero when no request is set
module niosduino_rr_pick #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_grant = '0;
    for (int k = 1; k <= N; k++) begin
      int w_idx;
      w_idx = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/niosduino_pio_arbiter.sv
// niosduino_pio_arbiter
// Round-robin arbiter sharing the single Avalon-MM register port of the
// NIOSDuino bidirectional PIO between NUM_REQ requesters. One transaction is
// in flight at a time: IDLE accepts, ISSUE strobes the PIO for one cycle,
// RESP (reads only) returns the PIO's registered read data to the owner.
//
// Optional feature macro: NIOSDUINO_PIO_ARB_LOCK_EN
//   Adds req_lock; a requester accepted with its lock bit set keeps exclusive
//   ownership until one of its transactions is accepted with the bit clear.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   req_valid/write   : per-requester request and write flag
//   req_address       : 3 bits per requester, requester i at [3i+2:3i]
//   req_writedata     : DATA_W bits per requester
//   req_lock          : per-requester lock request (lock feature only)
//   req_ready         : one-cycle, one-hot accept pulse
//   rsp_valid         : one-cycle, one-hot read-response pulse
//   rsp_readdata      : read data while rsp_valid is set, otherwise 0
//   busy              : FSM not in IDLE
//   pio_*             : Avalon-MM master side towards the PIO
module niosduino_pio_arbiter
  import niosduino_pio_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
`ifdef NIOSDUINO_PIO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_readdata,
  output logic                      busy,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [ADDR_W-1:0]         pio_address,
  output logic [DATA_W-1:0]         pio_writedata,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arbState_t          r_state;
  arbState_t          w_nextState;
  logic [PTR_W-1:0]   r_lastGrant;
  logic               r_cmdWrite;
  logic [ADDR_W-1:0]  r_cmdAddr;
  logic [DATA_W-1:0]  r_cmdData;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_winIdx;
  logic               w_accept;

  // Lock narrows the eligible set to the lock owner only.
`ifdef NIOSDUINO_PIO_ARB_LOCK_EN
  logic             r_lockActive;
  logic [PTR_W-1:0] r_lockOwner;

  always_comb begin
    w_eligible = req_valid;
    if (r_lockActive) begin
      w_eligible = req_valid & (NUM_REQ'(1) << r_lockOwner);
    end
  end

  // While locked only the owner can be accepted, so an unlocked accept
  // always comes from the owner and releases the lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lockActive <= 1'b0;
      r_lockOwner  <= '0;
    end else if (w_accept) begin
      if (req_lock[w_winIdx]) begin
        r_lockActive <= 1'b1;
        r_lockOwner  <= w_winIdx;
      end else begin
        r_lockActive <= 1'b0;
      end
    end
  end
`else
  assign w_eligible = req_valid;
`endif

  niosduino_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_lastGrant),
    .o_grant (w_grant)
  );

  assign w_winIdx = PTR_W'(oneHotToIdx(MAX_REQ'(w_grant)));

  // Command registers only change on accept, so outside ISSUE the PIO
  // address and data simply hold the last command.
  assign pio_address   = r_cmdAddr;
  assign pio_writedata = r_cmdData;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_accept       = 1'b0;
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_readdata   = '0;
    busy           = 1'b1;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|w_eligible) begin
          w_accept    = 1'b1;
          req_ready   = w_grant;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = ~r_cmdWrite;
        w_nextState    = r_cmdWrite ? IDLE : RESP;
      end
      RESP: begin
        // The PIO registered its read mux while we held cmd_addr in ISSUE.
        rsp_valid    = NUM_REQ'(1) << r_lastGrant;
        rsp_readdata = pio_readdata;
        w_nextState  = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_nextState = IDLE;
      end
    endcase
  end

  // last_grant doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant <= PTR_W'(NUM_REQ - 1);
      r_cmdWrite  <= 1'b0;
      r_cmdAddr   <= '0;
      r_cmdData   <= '0;
    end else if (w_accept) begin
      r_lastGrant <= w_winIdx;
      r_cmdWrite  <= req_write[w_winIdx];
      r_cmdAddr   <= req_address[w_winIdx*ADDR_W +: ADDR_W];
      r_cmdData   <= req_writedata[w_winIdx*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_niosduino_pio_arbiter.sv
// tb_niosduino_pio_arbiter
// Bench for niosduino_pio_arbiter with NUM_REQ=2, DATA_W=32, connected to a
// small behavioural model of the NIOSDuino PIO (data_out, data_dir, bit-set,
// bit-clear, registered read mux). Per-cycle vectors cover the main flows;
// hand-written sequences cover reset during RESP and, when
// NIOSDUINO_PIO_ARB_LOCK_EN is defined, the lock feature.
`timescale 1ns/1ps
module tb_niosduino_pio_arbiter;
  import niosduino_pio_pkg::*;

  localparam logic [31:0] FF = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB1B1_0002;

  logic        clk;
  logic        reset_n;
  logic [1:0]  reqValid;
  logic [1:0]  reqWrite;
  logic [5:0]  reqAddress;
  logic [63:0] reqWritedata;
  logic [1:0]  reqLock;
  logic [1:0]  reqReady;
  logic [1:0]  rspValid;
  logic [31:0] rspReaddata;
  logic        busy;
  logic        pioChipselect;
  logic        pioWriteN;
  logic [2:0]  pioAddress;
  logic [31:0] pioWritedata;
  logic [31:0] pioReaddata;

  logic [31:0] pioPins;
  logic [31:0] pioDataOut;
  logic [31:0] pioDir;

  int vectorCount = 0;
  int failCount   = 0;

  niosduino_pio_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (reqValid),
    .req_write      (reqWrite),
    .req_address    (reqAddress),
    .req_writedata  (reqWritedata),
`ifdef NIOSDUINO_PIO_ARB_LOCK_EN
    .req_lock       (reqLock),
`endif
    .req_ready      (reqReady),
    .rsp_valid      (rspValid),
    .rsp_readdata   (rspReaddata),
    .busy           (busy),
    .pio_chipselect (pioChipselect),
    .pio_write_n    (pioWriteN),
    .pio_address    (pioAddress),
    .pio_writedata  (pioWritedata),
    .pio_readdata   (pioReaddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO model: pins read back through the direction mask, read mux registered every clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pioDataOut  <= '0;
      pioDir      <= '0;
      pioReaddata <= '0;
    end else begin
      if (pioChipselect && !pioWriteN) begin
        case (pioAddress)
          ADDR_DATA: pioDataOut <= pioWritedata;
          ADDR_DIR:  pioDir     <= pioWritedata;
          ADDR_SET:  pioDataOut <= pioDataOut | pioWritedata;
          ADDR_CLR:  pioDataOut <= pioDataOut & ~pioWritedata;
          default:   ;
        endcase
      end
      case (pioAddress)
        ADDR_DATA: pioReaddata <= (pioPins & ~pioDir) | (pioDataOut & pioDir);
        ADDR_DIR:  pioReaddata <= pioDir;
        default:   pioReaddata <= '0;
      endcase
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [1:0]  eReady;
    logic [1:0]  eRsp;
    logic        eCs;
    logic        eWn;
    logic        eBusy;
    logic [31:0] eRdata;
    logic [2:0]  eAddr;
    logic [31:0] eWdata;
  } vec_t;

  vec_t vecs[$];

  // Inputs change at the falling edge; outputs are sampled 2 ns later.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                               input logic [5:0] a, input logic [63:0] d,
                               input logic [1:0] lk);
    @(negedge clk);
    reqValid     = v;
    reqWrite     = w;
    reqAddress   = a;
    reqWritedata = d;
    reqLock      = lk;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eReady,
                             input logic [1:0] eRsp, input logic eCs,
                             input logic eWn, input logic eBusy,
                             input logic [31:0] eRdata, input logic checkPio,
                             input logic [2:0] eAddr, input logic [31:0] eWdata);
    logic [38:0] act;
    logic [38:0] exp;
    logic        bad;
    act = {reqReady, rspValid, pioChipselect, pioWriteN, busy, rspReaddata};
    exp = {eReady, eRsp, eCs, eWn, eBusy, eRdata};
    bad = (act !== exp);
    if (checkPio && ({pioAddress, pioWritedata} !== {eAddr, eWdata})) bad = 1'b1;
    vectorCount++;
    if (bad) begin
      failCount++;
      $display("[TB] FAIL %s: got ready=%b rsp=%b cs=%b wn=%b busy=%b rdata=%h addr=%0d wdata=%h; want ready=%b rsp=%b cs=%b wn=%b busy=%b rdata=%h addr=%0d wdata=%h",
               name, reqReady, rspValid, pioChipselect, pioWriteN, busy, rspReaddata,
               pioAddress, pioWritedata, eReady, eRsp, eCs, eWn, eBusy, eRdata,
               eAddr, eWdata);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reqValid = '0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    reqValid     = '0;
    reqWrite     = '0;
    reqAddress   = '0;
    reqWritedata = '0;
    reqLock      = '0;
    pioPins      = 32'h1234_5678;
    #3;
    checkOutput("reset_state", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    //              name               valid  write  addr{r1,r0}     wdata{r1,r0} ready  rsp   cs wn busy rdata          addr  wdata
    vecs.push_back('{"wr_dir_acc",     2'b01, 2'b01, {3'd0, 3'd1}, {32'h0, FF},  2'b01, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"wr_dir_strobe",  2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd1, FF});
    vecs.push_back('{"wr_dir_done",    2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"set_acc",        2'b01, 2'b01, {3'd0, 3'd4}, {32'h0, 32'h0F}, 2'b01, 2'b00, 0, 1, 0, 32'h0,       3'd0, 32'h0});
    vecs.push_back('{"set_strobe",     2'b10, 2'b10, {3'd5, 3'd0}, {32'h03, 32'h0}, 2'b00, 2'b00, 1, 0, 1, 32'h0,       3'd4, 32'h0F});
    vecs.push_back('{"clr_acc",        2'b10, 2'b10, {3'd5, 3'd0}, {32'h03, 32'h0}, 2'b10, 2'b00, 0, 1, 0, 32'h0,       3'd0, 32'h0});
    vecs.push_back('{"clr_strobe",     2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd5, 32'h03});
    vecs.push_back('{"rd_data_acc",    2'b10, 2'b00, {3'd0, 3'd0}, 64'h0,        2'b10, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rd_data_strobe", 2'b01, 2'b00, {3'd0, 3'd1}, 64'h0,        2'b00, 2'b00, 1, 1, 1, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rd_data_resp",   2'b01, 2'b00, {3'd0, 3'd1}, 64'h0,        2'b00, 2'b10, 0, 1, 1, 32'h0000_000C,  3'd0, 32'h0});
    vecs.push_back('{"rd_dir_acc",     2'b01, 2'b00, {3'd0, 3'd1}, 64'h0,        2'b01, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rd_dir_strobe",  2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 1, 1, 32'h0,          3'd1, 32'h0});
    vecs.push_back('{"rd_dir_resp",    2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b01, 0, 1, 1, FF,             3'd0, 32'h0});
    vecs.push_back('{"wr_dir0_acc",    2'b01, 2'b01, {3'd0, 3'd1}, 64'h0,        2'b01, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"wr_dir0_strobe", 2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd1, 32'h0});
    vecs.push_back('{"rd_pins_acc",    2'b10, 2'b00, {3'd0, 3'd0}, 64'h0,        2'b10, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rd_pins_strobe", 2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 1, 1, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rd_pins_resp",   2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b10, 0, 1, 1, 32'h1234_5678,  3'd0, 32'h0});
    vecs.push_back('{"rr_grant0_a",    2'b11, 2'b11, 6'd0,         {WB, WA},     2'b01, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rr_strobe0_a",   2'b11, 2'b11, 6'd0,         {WB, WA},     2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd0, WA});
    vecs.push_back('{"rr_grant1_a",    2'b11, 2'b11, 6'd0,         {WB, WA},     2'b10, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rr_strobe1_a",   2'b11, 2'b11, 6'd0,         {WB, WA},     2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd0, WB});
    vecs.push_back('{"rr_grant0_b",    2'b11, 2'b11, 6'd0,         {WB, WA},     2'b01, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rr_strobe0_b",   2'b11, 2'b11, 6'd0,         {WB, WA},     2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd0, WA});
    vecs.push_back('{"rr_grant1_b",    2'b11, 2'b11, 6'd0,         {WB, WA},     2'b10, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});
    vecs.push_back('{"rr_strobe1_b",   2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 1, 0, 1, 32'h0,          3'd0, WB});
    vecs.push_back('{"rr_idle",        2'b00, 2'b00, 6'd0,         64'h0,        2'b00, 2'b00, 0, 1, 0, 32'h0,          3'd0, 32'h0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata, 2'b00);
      checkOutput(vecs[i].name, vecs[i].eReady, vecs[i].eRsp, vecs[i].eCs, vecs[i].eWn,
                  vecs[i].eBusy, vecs[i].eRdata, vecs[i].eCs, vecs[i].eAddr, vecs[i].eWdata);
    end

    // Reset during RESP: in-flight read dropped, pointer back to requester 0.
    applyStimulus(2'b01, 2'b00, {3'd0, 3'd1}, 64'h0, 2'b00);
    checkOutput("rst_rd_acc", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b00, 2'b00, 6'd0, {32'h0, 32'h55}, 2'b00);
    checkOutput("rst_rd_strobe", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 3'd1, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_resp", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0, 32'h0);
    @(negedge clk);
    #2;
    checkOutput("rst_held", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3'd0, 32'h0);
    reset_n = 1'b1;
    applyStimulus(2'b00, 2'b00, 6'd0, 64'h0, 2'b00);
    checkOutput("rst_no_resp", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b11, 2'b11, 6'd0, {WB, WA}, 2'b00);
    checkOutput("rst_first_grant", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b10, 2'b10, 6'd0, {WB, WA}, 2'b00);
    checkOutput("rst_first_strobe", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 3'd0, WA);
    applyStimulus(2'b10, 2'b10, 6'd0, {WB, WA}, 2'b00);
    checkOutput("rst_second_grant", 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b00, 2'b00, 6'd0, 64'h0, 2'b00);

`ifdef NIOSDUINO_PIO_ARB_LOCK_EN
    // Locked read-modify-write of DIR by requester 0 while requester 1 waits.
    pulseReset();
    applyStimulus(2'b11, 2'b10, {3'd0, 3'd1}, {WB, 32'h0}, 2'b01);
    checkOutput("lock_rd_acc", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b10, 2'b10, {3'd0, 3'd1}, {WB, 32'h0}, 2'b00);
    checkOutput("lock_rd_strobe", 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 3'd1, 32'h0);
    applyStimulus(2'b10, 2'b10, {3'd0, 3'd1}, {WB, 32'h0}, 2'b00);
    checkOutput("lock_rd_resp", 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b10, 2'b10, {3'd0, 3'd1}, {WB, 32'h0}, 2'b00);
    checkOutput("lock_blocks_r1", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b11, 2'b11, {3'd0, 3'd1}, {WB, 32'h5}, 2'b00);
    checkOutput("lock_wr_acc", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b10, 2'b10, {3'd0, 3'd1}, {WB, 32'h5}, 2'b00);
    checkOutput("lock_wr_strobe", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 3'd1, 32'h5);
    applyStimulus(2'b10, 2'b10, {3'd0, 3'd1}, {WB, 32'h5}, 2'b00);
    checkOutput("lock_released", 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    applyStimulus(2'b00, 2'b00, 6'd0, 64'h0, 2'b00);
    checkOutput("lock_r1_strobe", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 3'd0, WB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/niosduino_pio_arbiter.md
# niosduino_pio_arbiter

Round-robin arbiter that shares the single Avalon-MM register port of the NIOSDuino 32-bit bidirectional PIO between `NUM_REQ` independent requesters, such as the CPU bridge and hardware sequencers. It serialises their read and write transactions, generates `chipselect`, `write_n`, `address` and `writedata` for the PIO, and returns read data to the owning requester. It sits between the requesters and the PIO in the NIOSDuino_Core system.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2–8.
- `DATA_W`, default 32: PIO data width.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester transaction request. Held until accepted.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_address`  in  NUM_REQ*3  PIO register address, packed with requester i at bits [3i+2:3i].
- `req_writedata`  in  NUM_REQ*DATA_W  write data, packed per requester.
- `req_lock`  in  NUM_REQ  hold the grant after this transaction. Present only with the lock feature.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse, one-hot.
- `rsp_valid`  out  NUM_REQ  one-cycle read-response pulse, one-hot.
- `rsp_readdata`  out  DATA_W  read data, valid while any `rsp_valid` bit is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `pio_chipselect`, `pio_write_n`  out  1  PIO slave strobes.
- `pio_address`  out  3  PIO register address.
- `pio_writedata`  out  DATA_W  PIO write data.
- `pio_readdata`  in  DATA_W  PIO registered read data.

## Operation
- FSM states and transitions:
  - IDLE: arbitrate. If any request is eligible, move to ISSUE.
  - ISSUE: drive the PIO for exactly one cycle. Go to RESP on a read, IDLE on a write.
  - RESP: forward read data to the owner, then go to IDLE.
- Arbitration in IDLE:
  - Search starts at `(last_grant+1) mod NUM_REQ` and takes the first requester with `req_valid` high.
  - The winner gets `req_ready` in the same cycle.
  - Its write flag, address and data are registered into the command registers, and `last_grant` is updated to the winner.
- ISSUE drives `pio_chipselect=1`, `pio_write_n=~cmd_write`, `pio_address=cmd_addr` and `pio_writedata=cmd_data`. Outside ISSUE: `chipselect=0`, `write_n=1`, address and data hold their last values.
- RESP asserts `rsp_valid[owner]=1` with `rsp_readdata=pio_readdata`. The PIO registers its read mux every clock, so this data is the value for `cmd_addr`. In all other cycles `rsp_readdata` is 0.
- Addresses are passed through unchecked:
  - Addresses 4 and 5 are the PIO bit-set and bit-clear writes.
  - Writes to 2, 3, 6 and 7 have no effect in the PIO.
  - Reads of addresses 2–7 return 0.
- `req_valid` deasserted before acceptance: the request is withdrawn with no side effects.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_readdata=0`, `busy=0`, `pio_chipselect=0`, `pio_write_n=1`, `pio_address=0`, `pio_writedata=0`.
- Reset pointer: `last_grant=NUM_REQ-1`, so requester 0 has first priority.
- Write: accept at cycle T, strobe at T+1, next accept no earlier than T+2. Sustained rate is one write per 2 cycles.
- Read: accept at T, strobe at T+1, `rsp_valid` at T+2, next accept no earlier than T+3.
- No request is accepted while `busy=1`. Simultaneous requests are resolved by rotation only.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight transaction is dropped. No `rsp_valid` is produced. The PIO sees at most the strobe already issued.

## Configuration
- `NIOSDUINO_PIO_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - Accepting a transaction with `req_lock[i]=1` sets `lock_owner=i`, and IDLE then considers only requester i.
  - The lock is released when requester i has a transaction accepted with `req_lock[i]=0`. Reset also releases it.
  - Use case: atomic read-modify-write of `data_dir`.
- Undefined: the `req_lock` port is absent, and arbitration is pure round-robin on every IDLE cycle.

## Structure
- Shared package `niosduino_pio_pkg` holds:
  - the register address constants: DATA=0, DIR=1, SET=4, CLR=5;
  - the FSM state enum (IDLE, ISSUE, RESP);
  - the address width of 3.
- One sub-module, `niosduino_rr_pick`: a combinational round-robin priority picker taking a request vector and pointer and returning a one-hot grant. It is reusable by other NIOSDuino arbiters.

## Test plan
- After reset, requester 0 writes addr 1 = 0xFFFF_FFFF → exactly one `pio_chipselect` cycle with `write_n=0`. `req_ready[0]` is one cycle ahead of it.
- Requesters 0 and 1 request continuously → grants alternate 0,1,0,1 with a 2-cycle write spacing.
- Requester 1 reads addr 0 with the PIO port driven to 0x1234_5678 → `rsp_valid[1]` is 2 cycles after `req_ready[1]` and `rsp_readdata=0x1234_5678`. `rsp_valid[0]` stays 0.
- Write addr 4 = 0x0F, then addr 5 = 0x03, from different requesters → PIO `data_out` reads back 0x0C.
- `reset_n` is pulsed low during RESP → no `rsp_valid`, all outputs return to reset values, and requester 0 is granted first afterwards.
- With `NIOSDUINO_PIO_ARB_LOCK_EN`: requester 0 reads DIR with lock, requester 1 is requesting, requester 0 writes DIR unlocked → requester 1 is granted only after requester 0's write.
